instruction_fetch_stage: RTL and testbench

Instruction fetch stage directly upstream of the controller/ALU-control/ALU/branch datapath. It holds the program counter and a word-addressed instruction memory, and registers the fetched instruction and PC+4 into the IF/ID pipeline register that feeds the controller's `Instruction` input. It consumes `PCSrc` and the branch target from the branch logic to redirect fetch. A bench-side write port loads the memory.

---
 rtl/instruction_fetch_stage.sv | 71 +++++++
 tb/tb_instruction_fetch_stage.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_stage.sv
// rtl/instruction_fetch_stage.sv - program counter, instruction memory and IF/ID pipeline register
// Redirect beats stall; a stall freezes the PC, IF/ID and the fetch counter together.
module instruction_fetch_stage #(
   parameter int          IMEM_DEPTH = 128,
   parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        PCSrc,
   input  logic [31:0] BranchTarget,
   input  logic        Stall,
   input  logic        ImemWrEn,
   input  logic [31:0] ImemWrAddr,
   input  logic [31:0] ImemWrData,
   output logic [31:0] PC,
   output logic [31:0] IF_ID_Instruction,
   output logic [31:0] IF_ID_PCPlus4,
   output logic        IF_ID_Valid,
   output logic [31:0] FetchCount
);

   localparam int AW = $clog2(IMEM_DEPTH);

   logic [31:0]   mem [IMEM_DEPTH] = '{default: 32'h0};
   logic [AW-1:0] rd_idx;
   logic [AW-1:0] wr_idx;
   logic          rd_in_range;
   logic          wr_in_range;
   logic [31:0]   rd_word;
   logic [31:0]   pc_plus4;
   logic          unused_addr_bits;

   assign rd_idx      = PC[AW+1:2];
   assign wr_idx      = ImemWrAddr[AW+1:2];
   assign rd_in_range = (PC[31:AW+2] == '0);
   assign wr_in_range = (ImemWrAddr[31:AW+2] == '0);
   assign rd_word     = rd_in_range ? mem[rd_idx] : 32'h0;
   assign pc_plus4    = PC + 32'd4;

   // Byte-lane bits of word addresses carry no information.
   assign unused_addr_bits = ^{ImemWrAddr[1:0], BranchTarget[1:0]};

   // Fetch reads the pre-edge array, so a same-cycle write is seen only on the next fetch.
   always @(posedge Clk) begin
      if (ImemWrEn && wr_in_range) begin
         mem[wr_idx] <= ImemWrData;
      end
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         PC                <= RESET_PC;
         IF_ID_Instruction <= 32'h0;
         IF_ID_PCPlus4     <= 32'h0;
         IF_ID_Valid       <= 1'b0;
         FetchCount        <= 32'h0;
      end else if (PCSrc) begin
         PC                <= {BranchTarget[31:2], 2'b00};
         IF_ID_Instruction <= 32'h0;
         IF_ID_PCPlus4     <= 32'h0;
         IF_ID_Valid       <= 1'b0;
      end else if (!Stall) begin
         PC                <= pc_plus4;
         IF_ID_Instruction <= rd_word;
         IF_ID_PCPlus4     <= pc_plus4;
         IF_ID_Valid       <= 1'b1;
         FetchCount        <= FetchCount + 32'd1;
      end
   end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// tb/tb_instruction_fetch_stage.sv - directed vector table plus randomized run against a reference model
module tb_instruction_fetch_stage;

   localparam int DEPTH = 128;

   logic        Clk = 1'b0;
   logic        Rst = 1'b0;
   logic        PCSrc = 1'b0;
   logic [31:0] BranchTarget = 32'h0;
   logic        Stall = 1'b0;
   logic        ImemWrEn = 1'b0;
   logic [31:0] ImemWrAddr = 32'h0;
   logic [31:0] ImemWrData = 32'h0;
   logic [31:0] PC, IF_ID_Instruction, IF_ID_PCPlus4, FetchCount;
   logic        IF_ID_Valid;
   logic [31:0] w_pc, w_inst, w_pp4, w_cnt;
   logic        w_valid;

   int errors = 0;
   int checks = 0;

   instruction_fetch_stage #(.IMEM_DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
      .Clk(Clk), .Rst(Rst), .PCSrc(PCSrc), .BranchTarget(BranchTarget), .Stall(Stall),
      .ImemWrEn(ImemWrEn), .ImemWrAddr(ImemWrAddr), .ImemWrData(ImemWrData),
      .PC(PC), .IF_ID_Instruction(IF_ID_Instruction), .IF_ID_PCPlus4(IF_ID_PCPlus4),
      .IF_ID_Valid(IF_ID_Valid), .FetchCount(FetchCount)
   );

   instruction_fetch_stage #(.IMEM_DEPTH(4), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
      .Clk(Clk), .Rst(Rst), .PCSrc(1'b0), .BranchTarget(32'h0), .Stall(1'b0),
      .ImemWrEn(1'b0), .ImemWrAddr(32'h0), .ImemWrData(32'h0),
      .PC(w_pc), .IF_ID_Instruction(w_inst), .IF_ID_PCPlus4(w_pp4),
      .IF_ID_Valid(w_valid), .FetchCount(w_cnt)
   );

   always #5 Clk = ~Clk;

   // Reference model: memory as a sparse word map, state as plain variables.
   logic [31:0] m_mem [int];
   logic [31:0] m_pc, m_inst, m_pp4, m_cnt;
   logic        m_valid;

   typedef struct {
      logic        pcsrc;
      logic [31:0] target;
      logic        stall;
      logic        wen;
      logic [31:0] waddr;
      logic [31:0] wdata;
      logic [31:0] e_pc;
      logic [31:0] e_inst;
      logic [31:0] e_pp4;
      logic        e_valid;
      logic [31:0] e_cnt;
   } vec_t;

   vec_t tbl [18];

   function automatic vec_t mk(logic pcsrc, logic [31:0] target, logic stall, logic wen,
                               logic [31:0] waddr, logic [31:0] wdata, logic [31:0] e_pc,
                               logic [31:0] e_inst, logic [31:0] e_pp4, logic e_valid,
                               logic [31:0] e_cnt);
      vec_t v;
      v = '{pcsrc, target, stall, wen, waddr, wdata, e_pc, e_inst, e_pp4, e_valid, e_cnt};
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_pc = 32'h0; m_inst = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0; m_cnt = 32'h0;
   endtask

   function automatic logic [31:0] m_read(logic [31:0] addr);
      if (64'(addr) >= 64'(DEPTH * 4)) return 32'h0;
      return m_mem.exists(int'(addr / 4)) ? m_mem[int'(addr / 4)] : 32'h0;
   endfunction

   // Drive one cycle's inputs, advance the model, then wait past the rising edge.
   task automatic cycle(input logic pcsrc, input logic [31:0] target, input logic stall,
                        input logic wen, input logic [31:0] waddr, input logic [31:0] wdata);
      PCSrc = pcsrc; BranchTarget = target; Stall = stall;
      ImemWrEn = wen; ImemWrAddr = waddr; ImemWrData = wdata;
      if (Rst) begin
         model_reset();
      end else if (pcsrc) begin
         m_pc = target & 32'hFFFF_FFFC; m_inst = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0;
      end else if (!stall) begin
         m_inst = m_read(m_pc); m_pp4 = m_pc + 32'd4; m_pc = m_pc + 32'd4;
         m_valid = 1'b1; m_cnt = m_cnt + 32'd1;
      end
      if (wen && 64'(waddr) < 64'(DEPTH * 4)) m_mem[int'(waddr / 4)] = wdata;
      @(posedge Clk);
      #1;
   endtask

   task automatic chk_model(input string tag);
      chk({tag, " pc"},    PC,                m_pc);
      chk({tag, " inst"},  IF_ID_Instruction, m_inst);
      chk({tag, " pp4"},   IF_ID_PCPlus4,     m_pp4);
      chk({tag, " valid"}, 32'(IF_ID_Valid),  32'(m_valid));
      chk({tag, " cnt"},   FetchCount,        m_cnt);
   endtask

   initial begin
      tbl[0]  = mk(0, 0,          0, 0, 0,          0,            32'h04,  32'h2001_0005, 32'h04,  1, 1);
      tbl[1]  = mk(0, 0,          0, 0, 0,          0,            32'h08,  32'h2002_0003, 32'h08,  1, 2);
      tbl[2]  = mk(0, 0,          0, 0, 0,          0,            32'h0C,  32'h0022_1820, 32'h0C,  1, 3);
      tbl[3]  = mk(0, 0,          0, 0, 0,          0,            32'h10,  32'h0000_0000, 32'h10,  1, 4);
      tbl[4]  = mk(0, 0,          0, 1, 32'h10,     32'hDEAD_BEEF, 32'h14, 32'h1111_0004, 32'h14,  1, 5);
      tbl[5]  = mk(1, 32'h10,     0, 0, 0,          0,            32'h10,  32'h0,         32'h0,   0, 5);
      tbl[6]  = mk(0, 0,          0, 0, 0,          0,            32'h14,  32'hDEAD_BEEF, 32'h14,  1, 6);
      tbl[7]  = mk(1, 32'h31,     0, 0, 0,          0,            32'h30,  32'h0,         32'h0,   0, 6);
      tbl[8]  = mk(0, 0,          0, 0, 0,          0,            32'h34,  32'hAAAA_0012, 32'h34,  1, 7);
      tbl[9]  = mk(1, 32'h04,     0, 0, 0,          0,            32'h04,  32'h0,         32'h0,   0, 7);
      tbl[10] = mk(0, 0,          1, 0, 0,          0,            32'h04,  32'h0,         32'h0,   0, 7);
      tbl[11] = mk(0, 0,          1, 0, 0,          0,            32'h04,  32'h0,         32'h0,   0, 7);
      tbl[12] = mk(0, 0,          1, 0, 0,          0,            32'h04,  32'h0,         32'h0,   0, 7);
      tbl[13] = mk(0, 0,          0, 0, 0,          0,            32'h08,  32'h2002_0003, 32'h08,  1, 8);
      tbl[14] = mk(1, 32'h200,    1, 0, 0,          0,            32'h200, 32'h0,         32'h0,   0, 8);
      tbl[15] = mk(0, 0,          0, 1, 32'h200,    32'h5555_5555, 32'h204, 32'h0,        32'h204, 1, 9);
      tbl[16] = mk(1, 32'h0,      0, 0, 0,          0,            32'h00,  32'h0,         32'h0,   0, 9);
      tbl[17] = mk(0, 0,          0, 0, 0,          0,            32'h04,  32'h2001_0005, 32'h04,  1, 10);

      model_reset();
      #1 Rst = 1'b1;
      #1;
      chk("reset pc",    PC,                32'h0);
      chk("reset inst",  IF_ID_Instruction, 32'h0);
      chk("reset pp4",   IF_ID_PCPlus4,     32'h0);
      chk("reset valid", 32'(IF_ID_Valid),  32'h0);
      chk("reset cnt",   FetchCount,        32'h0);
      chk("wrap reset pc", w_pc,            32'hFFFF_FFFC);

      cycle(0, 0, 0, 1, 32'h00, 32'h2001_0005);
      cycle(0, 0, 0, 1, 32'h04, 32'h2002_0003);
      cycle(0, 0, 0, 1, 32'h08, 32'h0022_1820);
      cycle(0, 0, 0, 1, 32'h0C, 32'h0000_0000);
      cycle(0, 0, 0, 1, 32'h10, 32'h1111_0004);
      cycle(0, 0, 0, 1, 32'h30, 32'hAAAA_0012);
      chk("held in reset pc", PC, 32'h0);
      Rst = 1'b0;

      for (int i = 0; i < 18; i++) begin
         cycle(tbl[i].pcsrc, tbl[i].target, tbl[i].stall, tbl[i].wen, tbl[i].waddr, tbl[i].wdata);
         chk($sformatf("row%0d pc", i),    PC,                   tbl[i].e_pc);
         chk($sformatf("row%0d inst", i),  IF_ID_Instruction,    tbl[i].e_inst);
         chk($sformatf("row%0d pp4", i),   IF_ID_PCPlus4,        tbl[i].e_pp4);
         chk($sformatf("row%0d valid", i), 32'(IF_ID_Valid),     32'(tbl[i].e_valid));
         chk($sformatf("row%0d cnt", i),   FetchCount,           tbl[i].e_cnt);
         if (i == 0) begin
            chk("wrap pc",    w_pc,            32'h0);
            chk("wrap pp4",   w_pp4,           32'h0);
            chk("wrap inst",  w_inst,          32'h0);
            chk("wrap valid", 32'(w_valid),    32'h1);
         end
      end

      // Asynchronous reset landing between edges while stalled.
      cycle(0, 0, 1, 0, 0, 0);
      #2 Rst = 1'b1;
      model_reset();
      #1;
      chk("async pc",    PC,               32'h0);
      chk("async inst",  IF_ID_Instruction, 32'h0);
      chk("async valid", 32'(IF_ID_Valid), 32'h0);
      chk("async cnt",   FetchCount,       32'h0);
      #1 Rst = 1'b0;
      cycle(0, 0, 0, 0, 0, 0);
      chk("post reset inst", IF_ID_Instruction, 32'h2001_0005);
      chk("post reset pc",   PC,                32'h4);
      cycle(1, 32'h10, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0);
      chk("mem kept 0x10", IF_ID_Instruction, 32'hDEAD_BEEF);

      for (int n = 0; n < 400; n++) begin
         logic        pcsrc, stall, wen;
         logic [31:0] target, waddr;
         pcsrc  = ($urandom_range(0, 4) == 0);
         stall  = ($urandom_range(0, 3) == 0);
         wen    = ($urandom_range(0, 2) == 0);
         case ($urandom_range(0, 5))
            0:       target = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            1:       target = $urandom;
            default: target = 32'($urandom_range(0, 600));
         endcase
         waddr = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 520));
         cycle(pcsrc, target, stall, wen, waddr, $urandom);
         chk_model($sformatf("rand%0d", n));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
